// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   state_t          - fetch FSM states (FETCH, HOLD, DRAIN)
//   NOP              - instruction word inserted as a pipeline bubble
//   DEFAULT_RESET_PC - PC loaded on reset unless the parent overrides it
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at PC
        HOLD  = 2'd1,   // fetched word parked in the holding buffer
        DRAIN = 2'd2    // waiting out a stale request before redirecting
    } state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_pc_next.sv
// F_pc_next
// Combinational next-PC priority mux for the fetch stage.
//   i_pc          - current PC
//   i_stall       - hazard stall; while set, redirects are not sampled
//   i_jump        - decode-stage jump (highest priority)
//   i_branch      - decode-stage branch taken
//   i_addr_jump   - jump target
//   i_addr_pcadd  - branch target
//   o_pc4         - sequential successor, wraps modulo 2^32
//   o_redirect    - a jump or branch is accepted this cycle
//   o_target      - redirect target (jump wins over branch)
module F_pc_next (
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_jump,
    input  logic        i_branch,
    input  logic [31:0] i_addr_jump,
    input  logic [31:0] i_addr_pcadd,
    output logic [31:0] o_pc4,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    always_comb begin
        o_pc4      = i_pc + 32'd4;
        o_redirect = !i_stall && (i_jump || i_branch);
        o_target   = i_jump ? i_addr_jump : i_addr_pcadd;
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: issues word requests to instruction memory and
// fills the IF/ID pipeline register.
//   i_clk, i_nrst               - clock, asynchronous active-low reset
//   i_con_stall                 - hazard stall; freezes PC and IF/ID
//   i_con_ifbranch, i_addr_pcadd- branch redirect and its target
//   i_con_jump, i_addr_jump     - jump redirect and its target
//   o_imem_req, o_imem_addr     - memory request and word address
//   i_imem_ack, i_imem_rdata    - single-cycle response and data
//   o_addr_pc4, o_data_instr,
//   o_con_valid                 - IF/ID register toward decode
//   o_dbg_state                 - current FSM state
//
// Handshake: once o_imem_req is high, o_imem_req and o_imem_addr stay
// unchanged until the cycle in which i_imem_ack is high; that cycle
// completes the transfer, and i_imem_ack may arrive in the same cycle the
// request is first raised.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_con_stall,
    input  logic        i_con_ifbranch,
    input  logic        i_con_jump,
    input  logic [31:0] i_addr_pcadd,
    input  logic [31:0] i_addr_jump,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_addr_pc4,
    output logic [31:0] o_data_instr,
    output logic        o_con_valid,
    output state_t      o_dbg_state
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] target_q, target_d;

    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;

    F_pc_next u_pc_next (
        .i_pc         (pc_q),
        .i_stall      (i_con_stall),
        .i_jump       (i_con_jump),
        .i_branch     (i_con_ifbranch),
        .i_addr_jump  (i_addr_jump),
        .i_addr_pcadd (i_addr_pcadd),
        .o_pc4        (pc_plus4),
        .o_redirect   (redirect),
        .o_target     (redirect_target)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc4_d       = pc4_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        target_d    = target_q;
        o_imem_req  = 1'b0;

        case (state_q)
            FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    if (i_con_stall) begin
                        // Decode can't take the word yet: park it and
                        // stop requesting until the stall clears.
                        buf_instr_d = i_imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        pc_d        = pc_plus4;
                        state_d     = HOLD;
                    end else if (redirect) begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                        pc_d    = redirect_target;
                    end else begin
                        pc4_d   = pc_plus4;
                        instr_d = i_imem_rdata;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (redirect) begin
                    // The request can't be withdrawn; remember where to go
                    // and let it complete in DRAIN.
                    instr_d  = NOP;
                    valid_d  = 1'b0;
                    target_d = redirect_target;
                    state_d  = DRAIN;
                end else if (!i_con_stall) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (!i_con_stall) begin
                    if (redirect) begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                        pc_d    = redirect_target;
                    end else begin
                        pc4_d   = buf_pc4_q;
                        instr_d = buf_instr_q;
                        valid_d = 1'b1;
                    end
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                // Stale request stays on the bus; its data is dropped.
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    pc_d    = target_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            pc4_q       <= 32'h0;
            instr_q     <= NOP;
            valid_q     <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_pc4_q   <= 32'h0;
            target_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            target_q    <= target_d;
        end
    end

    assign o_imem_addr  = pc_q;
    assign o_addr_pc4   = pc4_q;
    assign o_data_instr = instr_q;
    assign o_con_valid  = valid_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed and randomized-latency stimulus for fetch_stage. Each cycle the
// expected IF/ID contents are queued when inputs are driven and compared
// after the clock edge.
module tb_fetch_stage;
    import fetch_pkg::*;

    // clock / reset
    logic i_clk  = 1'b0;
    logic i_nrst = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        i_con_stall = 1'b0;
    logic        i_con_ifbranch = 1'b0;
    logic        i_con_jump = 1'b0;
    logic [31:0] i_addr_pcadd = 32'h0;
    logic [31:0] i_addr_jump = 32'h0;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] o_addr_pc4;
    logic [31:0] o_data_instr;
    logic        o_con_valid;
    state_t      o_dbg_state;

    fetch_stage dut (
        .i_clk          (i_clk),
        .i_nrst         (i_nrst),
        .i_con_stall    (i_con_stall),
        .i_con_ifbranch (i_con_ifbranch),
        .i_con_jump     (i_con_jump),
        .i_addr_pcadd   (i_addr_pcadd),
        .i_addr_jump    (i_addr_jump),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_rdata   (i_imem_rdata),
        .o_addr_pc4     (o_addr_pc4),
        .o_data_instr   (o_data_instr),
        .o_con_valid    (o_con_valid),
        .o_dbg_state    (o_dbg_state)
    );

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [64:0] exp_q[$];

    localparam logic [31:0] I_BASE = 32'h2008_0005;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [64:0] ifid(input logic [31:0] pc4, input logic [31:0] instr, input logic v);
        return {pc4, instr, v};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // driver
    task automatic drive(input logic s, input logic j, input logic b, input logic a, input logic [31:0] d);
        i_con_stall    = s;
        i_con_jump     = j;
        i_con_ifbranch = b;
        i_imem_ack     = a;
        i_imem_rdata   = d;
    endtask

    // Check request side now, queue the IF/ID expectation, clock, compare.
    task automatic tick(input logic e_req, input logic [31:0] e_addr, input state_t e_st, input logic [64:0] e_ifid);
        logic [64:0] want;
        #1;
        check("req", 65'(o_imem_req), 65'(e_req));
        if (e_req) check("addr", 65'(o_imem_addr), 65'(e_addr));
        check("state", 65'(o_dbg_state), 65'(e_st));
        exp_q.push_back(e_ifid);
        @(posedge i_clk);
        #1;
        want = exp_q.pop_front();
        check("ifid", {o_addr_pc4, o_data_instr, o_con_valid}, want);
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] e_pc4;
        int          w;

        // reset state
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check("rst_ifid", {o_addr_pc4, o_data_instr, o_con_valid}, 65'h0);
        check("rst_state", 65'(o_dbg_state), 65'(FETCH));
        check("rst_addr", 65'(o_imem_addr), 65'h0);
        i_nrst = 1'b1;

        // back-to-back fetches
        drive(0, 0, 0, 1, I_BASE);
        tick(1, 32'h0, FETCH, ifid(32'h4, I_BASE, 1));
        tick(1, 32'h4, FETCH, ifid(32'h8, I_BASE, 1));

        // ack for addr 8 under a 3-cycle stall
        drive(1, 0, 0, 1, 32'hAAAA_0008);
        tick(1, 32'h8, FETCH, ifid(32'h8, I_BASE, 1));
        drive(1, 0, 0, 0, 32'h0);
        tick(0, 32'h0, HOLD, ifid(32'h8, I_BASE, 1));
        tick(0, 32'h0, HOLD, ifid(32'h8, I_BASE, 1));
        drive(0, 0, 0, 0, 32'h0);
        tick(0, 32'h0, HOLD, ifid(32'hC, 32'hAAAA_0008, 1));

        // branch taken with ack in the same cycle
        i_addr_pcadd = 32'h40;
        drive(0, 0, 1, 1, 32'hDEAD_000C);
        tick(1, 32'hC, FETCH, ifid(32'hC, NOP, 0));
        drive(0, 0, 0, 0, 32'h0);
        tick(1, 32'h40, FETCH, ifid(32'hC, NOP, 0));
        drive(0, 0, 0, 1, 32'h1111_0040);
        tick(1, 32'h40, FETCH, ifid(32'h44, 32'h1111_0040, 1));

        // jump + branch while unacked: drain, then jump target
        i_addr_jump  = 32'h100;
        i_addr_pcadd = 32'h40;
        drive(0, 1, 1, 0, 32'h0);
        tick(1, 32'h44, FETCH, ifid(32'h44, NOP, 0));
        i_addr_pcadd = 32'h200;
        drive(0, 0, 1, 0, 32'h0);
        tick(1, 32'h44, DRAIN, ifid(32'h44, NOP, 0));
        drive(0, 0, 0, 1, 32'hBAD0_0044);
        tick(1, 32'h44, DRAIN, ifid(32'h44, NOP, 0));
        drive(0, 0, 0, 1, 32'h2222_0100);
        tick(1, 32'h100, FETCH, ifid(32'h104, 32'h2222_0100, 1));

        // PC wrap at the top of the address space
        i_addr_jump = 32'hFFFF_FFFC;
        drive(0, 1, 0, 1, 32'hBAD0_0104);
        tick(1, 32'h104, FETCH, ifid(32'h104, NOP, 0));
        drive(0, 0, 0, 1, 32'h3333_FFFC);
        tick(1, 32'hFFFF_FFFC, FETCH, ifid(32'h0, 32'h3333_FFFC, 1));
        drive(0, 0, 0, 1, I_BASE);
        tick(1, 32'h0, FETCH, ifid(32'h4, I_BASE, 1));

        // redirect out of HOLD discards the buffered word
        drive(1, 0, 0, 1, 32'h4444_0004);
        tick(1, 32'h4, FETCH, ifid(32'h4, I_BASE, 1));
        i_addr_pcadd = 32'h80;
        drive(0, 0, 1, 0, 32'h0);
        tick(0, 32'h0, HOLD, ifid(32'h4, NOP, 0));
        drive(0, 0, 0, 1, 32'h5555_0080);
        tick(1, 32'h80, FETCH, ifid(32'h84, 32'h5555_0080, 1));

        // stall without ack ignores a concurrent jump
        i_addr_jump = 32'h500;
        drive(1, 1, 0, 0, 32'h0);
        tick(1, 32'h84, FETCH, ifid(32'h84, 32'h5555_0080, 1));
        drive(0, 0, 0, 1, 32'h6666_0084);
        tick(1, 32'h84, FETCH, ifid(32'h88, 32'h6666_0084, 1));

        // random memory latency
        p     = 32'h88;
        e_pc4 = 32'h88;
        for (int n = 0; n < 16; n++) begin
            w = $urandom_range(0, 3);
            for (int k = 0; k < w; k++) begin
                drive(0, 0, 0, 0, 32'h0);
                tick(1, p, FETCH, ifid(e_pc4, NOP, 0));
            end
            drive(0, 0, 0, 1, mem_word(p));
            tick(1, p, FETCH, ifid(p + 32'd4, mem_word(p), 1));
            e_pc4 = p + 32'd4;
            p     = p + 32'd4;
        end

        // reset pulse during DRAIN abandons the saved target
        i_addr_jump = 32'h300;
        drive(0, 1, 0, 0, 32'h0);
        tick(1, p, FETCH, ifid(e_pc4, NOP, 0));
        drive(0, 0, 0, 0, 32'h0);
        #1;
        check("drain_state", 65'(o_dbg_state), 65'(DRAIN));
        i_nrst = 1'b0;
        #1;
        check("arst_ifid", {o_addr_pc4, o_data_instr, o_con_valid}, 65'h0);
        check("arst_state", 65'(o_dbg_state), 65'(FETCH));
        check("arst_addr", 65'(o_imem_addr), 65'h0);
        #1;
        i_nrst = 1'b1;
        drive(0, 0, 0, 1, I_BASE);
        tick(1, 32'h0, FETCH, ifid(32'h4, I_BASE, 1));
        tick(1, 32'h4, FETCH, ifid(32'h8, I_BASE, 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
